ifft_serializer: RTL

IFFT_SERIALIZER -- requirements
Module: ifft_serializer

---
 rtl/ifft_serializer.sv | 86 ++++++++
 1 files changed

// File: rtl/ifft_serializer.sv
// rtl/ifft_serializer.sv - captures a scaled IFFT frame and streams it out one complex sample per handshake
module ifft_serializer #(
   parameter int N  = 16,
   parameter int W  = 16,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic signed [W:0] x [N][1:0],
   output logic              in_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic signed [W:0] out_re,
   output logic signed [W:0] out_im,
   output logic [IW-1:0]     out_idx,
   output logic              out_last,
   output logic [15:0]       frame_cnt
);

   localparam logic [0:0] S_IDLE   = 1'b0;
   localparam logic [0:0] S_STREAM = 1'b1;
   localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

   logic [0:0]        state_q, state_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [15:0]       frame_cnt_q, frame_cnt_d;
   logic signed [W:0] frame_q [N][1:0];

   logic at_last;
   logic accept;
   logic xfer;

   assign at_last   = (idx_q == LAST_IDX);
   assign out_valid = (state_q == S_STREAM);
   // A new frame may enter on the same edge that retires the last sample.
   assign in_ready  = (state_q == S_IDLE) || (out_valid && at_last && out_ready);
   assign accept    = in_valid && in_ready;
   assign xfer      = out_valid && out_ready;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      frame_cnt_d = frame_cnt_q;
      if (state_q == S_IDLE) begin
         if (accept) begin
            state_d = S_STREAM;
            idx_d   = '0;
         end
      end else if (xfer) begin
         if (!at_last) begin
            idx_d = idx_q + 1'b1;
         end else begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            idx_d       = '0;
            state_d     = accept ? S_STREAM : S_IDLE;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   // Payload storage is left unreset; outputs are gated by out_valid instead.
   always_ff @(posedge clk) begin
      if (accept) begin
         frame_q <= x;
      end
   end

   assign out_re    = out_valid ? frame_q[idx_q][0] : '0;
   assign out_im    = out_valid ? frame_q[idx_q][1] : '0;
   assign out_idx   = out_valid ? idx_q : '0;
   assign out_last  = out_valid && at_last;
   assign frame_cnt = frame_cnt_q;

endmodule
